// File: rtl/thermo_ctrl.sv
// Thermostat controller: programmable setpoint/hysteresis, mode select,
// and min-on / min-off dwell timers that prevent actuator short-cycling.
module thermo_ctrl #(
  parameter int WIDTH   = 5,
  parameter int HW      = 3,
  parameter int MIN_ON  = 4,
  parameter int MIN_OFF = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] setpoint,
  input  logic [HW-1:0]    hyst,
  input  logic [WIDTH-1:0] temperature,
  output logic             heating,
  output logic             cooling,
  output logic             lockout,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2
  } state_t;

  localparam int MAXC = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] ON_LOAD  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(MIN_OFF);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [WIDTH:0] TMAX    = {1'b0, {WIDTH{1'b1}}};

  state_t          state_q, state_n;
  logic [CW-1:0]   on_q, on_n, off_q, off_n;
  logic            heating_q, cooling_q;

  logic [WIDTH:0]  sp_x, hy_x, tp_x, sum_x, low_x, high_x;
  logic            heat_en, cool_en, want_heat, want_cool;

  // Thresholds use one extra bit so clamping/saturation never wraps.
  always_comb begin
    sp_x   = {1'b0, setpoint};
    hy_x   = (WIDTH + 1)'(hyst);
    tp_x   = {1'b0, temperature};
    sum_x  = sp_x + hy_x;
    low_x  = (hy_x > sp_x) ? '0 : (sp_x - hy_x);
    high_x = (sum_x > TMAX) ? TMAX : sum_x;
  end

  // mode: 0=OFF, 1=HEAT_ONLY, 2=COOL_ONLY, 3=AUTO
  assign heat_en   = mode[0];
  assign cool_en   = mode[1];
  assign want_heat = heat_en && (tp_x <= low_x);
  assign want_cool = cool_en && (tp_x >= high_x);

  always_comb begin
    state_n = state_q;
    on_n    = (on_q != '0) ? (on_q - ONE) : '0;
    off_n   = off_q;
    case (state_q)
      IDLE: begin
        off_n = (off_q != '0) ? (off_q - ONE) : '0;
        if (off_q == '0) begin
          if (want_heat) begin
            state_n = HEAT;
            on_n    = ON_LOAD;
          end else if (want_cool) begin
            state_n = COOL;
            on_n    = ON_LOAD;
          end
        end
      end
      HEAT: begin
        if (!heat_en || ((tp_x >= sp_x) && (on_q == '0))) begin
          state_n = IDLE;
          off_n   = OFF_LOAD;
        end
      end
      COOL: begin
        if (!cool_en || ((tp_x <= sp_x) && (on_q == '0))) begin
          state_n = IDLE;
          off_n   = OFF_LOAD;
        end
      end
      default: begin
        state_n = IDLE;
        off_n   = OFF_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      on_q      <= '0;
      off_q     <= OFF_LOAD;
      heating_q <= 1'b0;
      cooling_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      on_q      <= on_n;
      off_q     <= off_n;
      heating_q <= (state_n == HEAT);
      cooling_q <= (state_n == COOL);
    end
  end

  assign heating = heating_q;
  assign cooling = cooling_q;
  assign lockout = (off_q != '0);
  assign state   = state_q;

endmodule

// File: doc/thermo_ctrl.md
Name: thermo_ctrl

Overview:
Parametrised thermostat controller that generalises the fixed-threshold air-conditioning block. Temperature width, setpoint and hysteresis are programmable, and an operating mode selects heat-only, cool-only, auto or off. Minimum-on and minimum-off dwell timers protect the heater and compressor from short-cycling. The block sits between the temperature sensor register and the heating/cooling actuator drivers.

Parameters:
WIDTH, 5, temperature/setpoint width in bits (unsigned)
HW, 3, hysteresis input width in bits
MIN_ON, 4, minimum cycles heating/cooling stays asserted once on (>=1)
MIN_OFF, 3, minimum cycles both outputs stay low after any turn-off or reset (>=0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
mode  input  2  0=OFF, 1=HEAT_ONLY, 2=COOL_ONLY, 3=AUTO
setpoint  input  WIDTH  target temperature
hyst  input  HW  hysteresis half-band
temperature  input  WIDTH  current temperature sample
heating  output  1  heater drive, registered
cooling  output  1  cooler drive, registered
lockout  output  1  high while the min-off timer is running
state  output  2  0=IDLE, 1=HEAT, 2=COOL (3 unused)

Behaviour:
- Clock and reset: single clock domain. rst is sampled on the rising edge of clk only.
- Reset: state=IDLE, heating=0, cooling=0. The off-timer loads MIN_OFF, so lockout=1 for MIN_OFF cycles after rst deasserts (0 if MIN_OFF=0). A reset mid-HEAT or mid-COOL drops the outputs on that edge, with no min-on hold.
- Thresholds: computed combinationally at WIDTH+1 bits.
  - LOW = setpoint - hyst, clamped at 0.
  - HIGH = setpoint + hyst, saturated at 2^WIDTH-1.
- Outputs: heating = (state==HEAT) and cooling = (state==COOL), both registered. A decision made on edge N is visible after edge N. heating and cooling are never both 1.
- IDLE:
  - If lockout=1, stay IDLE.
  - Else go to HEAT if mode is HEAT_ONLY or AUTO and temperature <= LOW.
  - Else go to COOL if mode is COOL_ONLY or AUTO and temperature >= HIGH.
  - Heat has priority when both conditions are true (hyst=0, temperature==setpoint).
- Entering HEAT or COOL loads the on-timer with MIN_ON-1. The timer decrements each cycle, floored at 0.
- HEAT leaves to IDLE when:
  - (temperature >= setpoint and on-timer==0), or
  - mode is OFF or COOL_ONLY. This exit is immediate and overrides the min-on hold.
- COOL leaves to IDLE when:
  - (temperature <= setpoint and on-timer==0), or
  - mode is OFF or HEAT_ONLY. This exit is immediate.
- No direct HEAT<->COOL transition; every path goes through IDLE.
- Off-timer:
  - Any transition into IDLE loads MIN_OFF. lockout = (off-timer != 0).
  - The timer decrements each cycle in IDLE.
  - The first cycle it can start again is the edge on which the off-timer reads 0.
- Inputs: setpoint, hyst and mode changes take effect on the next evaluating edge. No input latching.
- Counter width: clog2(max(MIN_ON, MIN_OFF)+1), minimum 1 bit.

Test Plan:
All scenarios use WIDTH=5, MIN_ON=4, MIN_OFF=3, setpoint=20, hyst=2, mode=AUTO unless stated.

1. Reset recovery: rst for 2 cycles with temperature=15.
   - lockout=1 for 3 cycles after release, heating=0 throughout.
   - heating=1 on the edge where the timer reaches 0. state=1.
2. Min-on hold: heating active, temperature raised to 25 one cycle after turn-on.
   - heating stays 1 for exactly 4 cycles total, then 0.
   - lockout=1 for 3 cycles. cooling stays 0 during lockout, then 1 (25 >= HIGH=22).
3. Cooling hysteresis: cooling active, temperature swept 23->21->20.
   - cooling holds at 21 and drops at 20 (on-timer expired). No heating at 20 or 19.
   - heating starts only at 18 after lockout ends.
4. Mode override: mode=OFF one cycle after heating turns on.
   - heating=0 on the next edge despite min-on. lockout=1 for 3 cycles.
   - mode=COOL_ONLY with temperature=10: heating stays 0 indefinitely.
5. Saturation boundaries:
   - setpoint=1, hyst=3, temperature=0: LOW clamps to 0, heating=1.
   - setpoint=30, hyst=3, temperature=31: HIGH saturates at 31, cooling=1. No wrap-around triggers.
6. Equal thresholds and mid-operation reset:
   - hyst=0, temperature=20: heating wins, cooling=0.
   - Assert rst while heating: heating=0 on that edge, state=0, lockout sequence restarts.
